pdm_mic_frontend: RTL and testbench

//  Microphone-side front end of the PDM audio path. Generates M_CLK/M_LRSEL for the
//  on-board PDM mic and samples M_DATA on the selected channel edge.

---
 rtl/pdm_mic_frontend.sv | 138 +++++++++++++
 tb/tb_pdm_mic_frontend.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pdm_mic_frontend.sv
// PDM microphone front end: mic clock generation, data capture
// and CIC decimation into a valid/ready PCM stream.
module pdm_mic_frontend #(
  parameter int CLK_FREQ          = 100_000_000,
  parameter int PDM_CLK_FREQ      = 1_800_000,
  parameter int DECIMATION_FACTOR = 64,
  parameter int CIC_STAGES        = 4,
  parameter int DATA_WIDTH        = 16,
  parameter int PDM_CHANNEL       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  output logic                  M_CLK,
  output logic                  M_LRSEL,
  input  logic                  M_DATA,
  output logic [DATA_WIDTH-1:0] pcm_data,
  output logic                  pcm_valid,
  input  logic                  pcm_ready,
  output logic                  overflow
);

  localparam int HALF_DIV = CLK_FREQ / (2 * PDM_CLK_FREQ);
  localparam int LOG2R    = $clog2(DECIMATION_FACTOR);
  localparam int W        = CIC_STAGES * LOG2R + 2;
  localparam int CW       = $clog2(HALF_DIV + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(HALF_DIV - 1);
  localparam logic SEL = (PDM_CHANNEL != 0);

  if (HALF_DIV < 2) begin : g_bad_div
    $error("HALF_DIV must be at least 2");
  end
  if ((DECIMATION_FACTOR < 2) ||
      ((DECIMATION_FACTOR & (DECIMATION_FACTOR - 1)) != 0))
  begin : g_bad_r
    $error("DECIMATION_FACTOR must be a power of two >= 2");
  end
  if (DATA_WIDTH > W) begin : g_bad_dw
    $error("DATA_WIDTH exceeds CIC register width");
  end
  if ((CIC_STAGES < 1) || (CIC_STAGES > 6)) begin : g_bad_n
    $error("CIC_STAGES must be 1..6");
  end

  logic [CW-1:0]    div_cnt;
  logic [1:0]       sync;
  logic [LOG2R-1:0] dec_cnt;
  logic [W-1:0]     integ    [CIC_STAGES];
  logic [W-1:0]     integ_nx [CIC_STAGES];
  logic [W-1:0]     dly      [CIC_STAGES];
  logic [W-1:0]     comb_s   [CIC_STAGES];
  logic [W-1:0]     x;
  logic             wrap;
  logic             smp;
  logic             decim;

  assign M_LRSEL = SEL;
  assign wrap    = enable && (div_cnt == DIV_LAST);
  assign smp     = wrap && (M_CLK == SEL);
  assign decim   = smp && (dec_cnt == '1);

  // mic clock divider, held at zero while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      M_CLK   <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      M_CLK   <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      M_CLK   <= ~M_CLK;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // two-flop synchronizer for the asynchronous mic data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[0], M_DATA};
  end

  // integrator cascade and comb cascade, both settle in one cycle
  always_comb begin
    x = {{(W-1){~sync[1]}}, 1'b1};
    integ_nx[0] = integ[0] + x;
    for (int i = 1; i < CIC_STAGES; i++)
      integ_nx[i] = integ[i] + integ_nx[i-1];
    comb_s[0] = integ_nx[CIC_STAGES-1] - dly[0];
    for (int i = 1; i < CIC_STAGES; i++)
      comb_s[i] = comb_s[i-1] - dly[i];
  end

  // CIC state: integrators per sample, comb delays per output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt <= '0;
      for (int i = 0; i < CIC_STAGES; i++) begin
        integ[i] <= '0;
        dly[i]   <= '0;
      end
    end else if (!enable) begin
      dec_cnt <= '0;
      for (int i = 0; i < CIC_STAGES; i++) begin
        integ[i] <= '0;
        dly[i]   <= '0;
      end
    end else if (smp) begin
      dec_cnt <= dec_cnt + 1'b1;
      for (int i = 0; i < CIC_STAGES; i++)
        integ[i] <= integ_nx[i];
      if (decim) begin
        dly[0] <= integ_nx[CIC_STAGES-1];
        for (int i = 1; i < CIC_STAGES; i++)
          dly[i] <= comb_s[i-1];
      end
    end
  end

  // output register with overwrite detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcm_data  <= '0;
      pcm_valid <= 1'b0;
      overflow  <= 1'b0;
    end else if (!enable) begin
      pcm_valid <= 1'b0;
    end else if (decim) begin
      pcm_data  <= comb_s[CIC_STAGES-1][W-1 -: DATA_WIDTH];
      pcm_valid <= 1'b1;
      if (pcm_valid && !pcm_ready) overflow <= 1'b1;
    end else if (pcm_valid && pcm_ready) begin
      pcm_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pdm_mic_frontend.sv
// Bench for pdm_mic_frontend: clock timing, CIC settled values,
// handshake/overflow, reset, enable flush and right-channel capture.
module tb_pdm_mic_frontend;

  localparam int PER    = 3456;
  localparam int NOUT   = 6;
  localparam int SETTLE = 4;

  typedef struct {
    int          t;
    logic [15:0] d;
  } obs_t;

  typedef struct {
    string       name;
    int          mode;
    logic [15:0] expv;
    bit          right;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en0, en1, rdy;
  logic        mclk0, mclk1, lr0, lr1;
  logic        mdata0;
  logic        mdata1 = 1'b0;
  logic        alt_bit = 1'b0;
  logic [15:0] pcm_data0, pcm_data1;
  logic        pcm_valid0, pcm_valid1, ovf0, ovf1;
  logic        mon0, mon1;
  int          mode;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  obs_t        obs0[$];
  obs_t        obs1[$];
  logic [15:0] exp0[$];
  logic [15:0] exp1[$];
  vec_t        vt[3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign mdata0 = (mode == 2) ? alt_bit : (mode == 0);
  always @(negedge mclk0) alt_bit = ~alt_bit;
  always @(posedge mclk1) mdata1 = 1'b1;

  pdm_mic_frontend u_left (
    .clk(clk), .rst_n(rst_n), .enable(en0),
    .M_CLK(mclk0), .M_LRSEL(lr0), .M_DATA(mdata0),
    .pcm_data(pcm_data0), .pcm_valid(pcm_valid0),
    .pcm_ready(rdy), .overflow(ovf0)
  );

  pdm_mic_frontend #(.PDM_CHANNEL(1)) u_right (
    .clk(clk), .rst_n(rst_n), .enable(en1),
    .M_CLK(mclk1), .M_LRSEL(lr1), .M_DATA(mdata1),
    .pcm_data(pcm_data1), .pcm_valid(pcm_valid1),
    .pcm_ready(rdy), .overflow(ovf1)
  );

  always @(negedge clk) begin
    if (mon0 && pcm_valid0 && rdy) obs0.push_back('{cyc, pcm_data0});
    if (mon1 && pcm_valid1 && rdy) obs1.push_back('{cyc, pcm_data1});
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic wait_outs(input int n0, input int n1);
    for (int i = 0; i < (NOUT + 1) * PER &&
         (obs0.size() < n0 || obs1.size() < n1); i++)
      @(negedge clk);
    mon0 = 1'b0;
    mon1 = 1'b0;
  endtask

  task automatic check_q(input string nm, input int which,
                         input int t0, input int lat);
    obs_t        o;
    int          last;
    logic [15:0] e;
    last = 0;
    chk({nm, " count"}, (which == 0) ? obs0.size() : obs1.size(), NOUT);
    for (int k = 1; k <= NOUT; k++) begin
      if (which == 0) begin
        if (obs0.size() == 0) break;
        o = obs0.pop_front();
      end else begin
        if (obs1.size() == 0) break;
        o = obs1.pop_front();
      end
      if (k == 1) chk({nm, " first"}, o.t - t0, lat);
      else        chk({nm, " period"}, o.t - last, PER);
      last = o.t;
      if (k > SETTLE) begin
        if (which == 0) e = exp0.pop_front();
        else            e = exp1.pop_front();
        chk({nm, " data"}, o.d, e);
      end
    end
  endtask

  initial begin
    int t0;
    vt[0] = '{"alt",  2, 16'h0000, 1'b0};
    vt[1] = '{"zero", 1, 16'hC000, 1'b0};
    vt[2] = '{"one",  0, 16'h4000, 1'b1};

    rst_n = 1'b0; en0 = 1'b0; en1 = 1'b0; rdy = 1'b1;
    mode = 0; mon0 = 1'b0; mon1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst mclk", mclk0, 0);
    chk("rst lrsel", lr0, 0);
    chk("rst lrsel right", lr1, 1);
    chk("rst data", pcm_data0, 0);
    chk("rst valid", pcm_valid0, 0);
    chk("rst overflow", ovf0, 0);

    en0 = 1'b1; rst_n = 1'b1; t0 = cyc;
    for (int i = 0; i < 100 && !mclk0; i++) @(negedge clk);
    chk("mclk first rise", cyc - t0, 27);
    t0 = cyc;
    for (int i = 0; i < 100 && mclk0; i++) @(negedge clk);
    chk("mclk high", cyc - t0, 27);
    t0 = cyc;
    for (int i = 0; i < 100 && !mclk0; i++) @(negedge clk);
    chk("mclk low", cyc - t0, 27);
    chk("lrsel run", lr0, 0);

    foreach (vt[v]) begin
      en0 = 1'b0;
      en1 = 1'b0;
      repeat (10) @(negedge clk);
      chk({vt[v].name, " flush mclk"}, mclk0, 0);
      chk({vt[v].name, " flush valid"}, pcm_valid0, 0);
      mode = vt[v].mode;
      obs0.delete(); obs1.delete();
      exp0.delete(); exp1.delete();
      repeat (NOUT - SETTLE) begin
        exp0.push_back(vt[v].expv);
        if (vt[v].right) exp1.push_back(16'h4000);
      end
      mon0 = 1'b1;
      mon1 = vt[v].right;
      en0 = 1'b1;
      en1 = vt[v].right;
      t0 = cyc;
      wait_outs(NOUT, vt[v].right ? NOUT : 0);
      check_q(vt[v].name, 0, t0, 27 + 54 * 63);
      if (vt[v].right) begin
        check_q("right", 1, t0, 54 * 64);
        chk("right lrsel", lr1, 1);
      end
    end
    en1 = 1'b0;

    for (int i = 0; i < PER + 100 && !pcm_valid0; i++) @(negedge clk);
    @(negedge clk);
    rdy = 1'b0;
    repeat (PER / 2) @(negedge clk);
    chk("hold idle valid", pcm_valid0, 0);
    repeat (PER) @(negedge clk);
    chk("hold one valid", pcm_valid0, 1);
    chk("hold one overflow", ovf0, 0);
    repeat (PER) @(negedge clk);
    chk("hold two valid", pcm_valid0, 1);
    chk("hold two overflow", ovf0, 1);
    chk("hold two data", pcm_data0, 16'h4000);
    rdy = 1'b1;
    @(negedge clk);
    chk("drain valid", pcm_valid0, 0);
    chk("drain overflow", ovf0, 1);

    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("pulse mclk", mclk0, 0);
    chk("pulse data", pcm_data0, 0);
    chk("pulse valid", pcm_valid0, 0);
    chk("pulse overflow", ovf0, 0);
    chk("pulse lrsel right", lr1, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
